// File: rtl/maze_path_player.sv
// Replays a solved maze path: buffers 2-bit moves from the solver in a small FIFO
// and walks an (x, y) cursor over a 16x16 grid, one step every STEP_DIV clocks.
module maze_path_player #(
    parameter int START_X    = 0,
    parameter int START_Y    = 0,
    parameter int STEP_DIV   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic       move_valid,
    input  logic [1:0] move,
    input  logic       move_last,
    input  logic       clear,
    output logic       run,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic       step,
    output logic [7:0] steps,
    output logic       busy,
    output logic       complete,
    output logic       oob,
    output logic       overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(STEP_DIV - 1);
    localparam logic [AW:0]   FIFO_FULL    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [3:0]    X0           = 4'(START_X);
    localparam logic [3:0]    Y0           = 4'(START_Y);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    state_t          state_q, state_d;
    logic [1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [TW-1:0]   timer;
    logic            last_seen;

    logic            pacing, fifo_empty, fifo_full;
    logic            push_req, push, pop, drop, arm;
    logic [8:0]      mv;

    // Returns {oob, new_x, new_y}; an off-grid target leaves the cursor in place.
    function automatic logic [8:0] apply_move(input logic [3:0] cx, input logic [3:0] cy,
                                              input logic [1:0] dir);
        logic signed [5:0] tx, ty;
        tx = signed'({2'b00, cx});
        ty = signed'({2'b00, cy});
        unique case (dir)
            2'b00: ty = ty - 6'sd1;
            2'b01: tx = tx + 6'sd1;
            2'b10: tx = tx - 6'sd1;
            2'b11: ty = ty + 6'sd1;
        endcase
        if (tx < 6'sd0 || tx > 6'sd15 || ty < 6'sd0 || ty > 6'sd15)
            return {1'b1, cx, cy};
        return {1'b0, tx[3:0], ty[3:0]};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign pacing     = (state_q == RUN) || (state_q == DRAIN);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FIFO_FULL);
    assign push_req   = move_valid && (state_q == RUN) && !clear;
    assign pop        = pacing && (timer == '0) && !fifo_empty && !clear;
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;
    assign arm        = (state_q == IDLE) && done && !clear;
    assign mv         = apply_move(x, y, mem[rd_ptr]);

    always_comb begin
        state_d  = state_q;
        run      = (state_q == RUN);
        busy     = pacing;
        complete = (state_q == FINISH);
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:   if (done) state_d = RUN;
                RUN:    if (push_req && move_last) state_d = DRAIN;
                DRAIN:  if (fifo_empty && last_seen) state_d = FINISH;
                FINISH: state_d = FINISH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= move;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            timer     <= '0;
            last_seen <= 1'b0;
            x         <= X0;
            y         <= Y0;
            steps     <= '0;
            step      <= 1'b0;
            oob       <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q <= state_d;
            step    <= pop;
            if (clear) begin
                // Flush the buffer but keep steps and sticky flags for inspection.
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                timer  <= '0;
                x      <= X0;
                y      <= Y0;
            end else if (arm) begin
                steps     <= '0;
                oob       <= 1'b0;
                overflow  <= 1'b0;
                last_seen <= 1'b0;
                timer     <= '0;
                x         <= X0;
                y         <= Y0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                unique case ({push, pop})
                    2'b10:   count <= count + (AW + 1)'(1);
                    2'b01:   count <= count - (AW + 1)'(1);
                    default: count <= count;
                endcase
                if (drop) overflow <= 1'b1;
                if (push_req && move_last) last_seen <= 1'b1;
                if (pop) begin
                    oob   <= oob | mv[8];
                    x     <= mv[7:4];
                    y     <= mv[3:0];
                    steps <= sat_inc(steps);
                    timer <= TIMER_RELOAD;
                end else if (pacing && timer != '0) begin
                    timer <= timer - TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_maze_path_player.sv
// Bench for maze_path_player: table of short paths on a STEP_DIV=4 instance plus
// overflow / full-with-pop / clear sequences; step pulses are scored against a queue.
module tb_maze_path_player;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       done = 1'b0;
    logic       move_valid = 1'b0;
    logic [1:0] move = 2'b00;
    logic       move_last = 1'b0;
    logic       clear = 1'b0;

    logic       run_a, step_a, busy_a, complete_a, oob_a, overflow_a;
    logic [3:0] x_a, y_a;
    logic [7:0] steps_a;
    logic       run_b, step_b, busy_b, complete_b, oob_b, overflow_b;
    logic [3:0] x_b, y_b;
    logic [7:0] steps_b;

    maze_path_player #(.START_X(0), .START_Y(0), .STEP_DIV(4), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst(rst), .done(done), .move_valid(move_valid), .move(move),
        .move_last(move_last), .clear(clear), .run(run_a), .x(x_a), .y(y_a),
        .step(step_a), .steps(steps_a), .busy(busy_a), .complete(complete_a),
        .oob(oob_a), .overflow(overflow_a)
    );

    maze_path_player #(.START_X(0), .START_Y(0), .STEP_DIV(16), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .rst(rst), .done(done), .move_valid(move_valid), .move(move),
        .move_last(move_last), .clear(clear), .run(run_b), .x(x_b), .y(y_b),
        .step(step_b), .steps(steps_b), .busy(busy_b), .complete(complete_b),
        .oob(oob_b), .overflow(overflow_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected cursor {x,y} after one move; off-grid moves leave it unchanged.
    function automatic logic [7:0] model_step(input logic [7:0] pos, input logic [1:0] d);
        int px, py;
        px = int'(pos[7:4]);
        py = int'(pos[3:0]);
        case (d)
            2'b00: py = py - 1;
            2'b01: px = px + 1;
            2'b10: px = px - 1;
            default: py = py + 1;
        endcase
        if (px < 0 || px > 15 || py < 0 || py > 15) return pos;
        return {4'(px), 4'(py)};
    endfunction

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int         st_a[$];
    int         st_b[$];
    bit         mon_a = 1'b0;
    bit         mon_b = 1'b0;
    logic [7:0] e_a, e_b;

    always @(negedge clk) begin
        if (mon_a && step_a) begin
            st_a.push_back(cyc);
            if (q_a.size() == 0) chk("step_a_unexpected", 1, 0);
            else begin
                e_a = q_a.pop_front();
                chk("step_a_xy", int'({x_a, y_a}), int'(e_a));
            end
        end
        if (mon_b && step_b) begin
            st_b.push_back(cyc);
            if (q_b.size() == 0) chk("step_b_unexpected", 1, 0);
            else begin
                e_b = q_b.pop_front();
                chk("step_b_xy", int'({x_b, y_b}), int'(e_b));
            end
        end
    end

    typedef struct {
        int         n;
        logic [7:0] mvs;
        int         ex;
        int         ey;
        int         esteps;
        int         eoob;
    } vec_t;

    vec_t tbl[5];

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_complete_a(input int limit);
        for (int t = 0; t < limit && !complete_a; t++) tick();
        chk("complete_a_wait", int'(complete_a), 1);
    endtask

    task automatic wait_complete_b(input int limit);
        for (int t = 0; t < limit && !complete_b; t++) tick();
        chk("complete_b_wait", int'(complete_b), 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pos;
        logic [1:0] m;
        int         nsteps;

        tbl[0] = '{3, 8'b00_11_01_01, 2, 1, 3, 0};
        tbl[1] = '{1, 8'b00_00_00_00, 0, 0, 1, 1};
        tbl[2] = '{2, 8'b00_00_11_10, 0, 1, 2, 1};
        tbl[3] = '{4, 8'b00_01_11_11, 1, 1, 4, 0};
        tbl[4] = '{1, 8'b00_00_00_11, 0, 1, 1, 0};

        // Reset held low for two edges
        tick();
        tick();
        chk("rst_x", int'(x_a), 0);
        chk("rst_y", int'(y_a), 0);
        chk("rst_run", int'(run_a), 0);
        chk("rst_step", int'(step_a), 0);
        chk("rst_steps", int'(steps_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_complete", int'(complete_a), 0);
        chk("rst_oob", int'(oob_a), 0);
        chk("rst_overflow", int'(overflow_a), 0);
        rst = 1'b1;
        tick();
        chk("idle_run", int'(run_a), 0);

        // Table-driven paths on the STEP_DIV=4 instance
        mon_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_clear();
            q_a.delete();
            st_a.delete();
            chk("arm_run_low", int'(run_a), 0);
            done = 1'b1;
            tick();
            chk("arm_run_high", int'(run_a), 1);
            pos = 8'h00;
            for (int k = 0; k < tbl[i].n; k++) begin
                m = tbl[i].mvs[2*k +: 2];
                move_valid = 1'b1;
                move = m;
                move_last = (k == tbl[i].n - 1);
                pos = model_step(pos, m);
                q_a.push_back(pos);
                tick();
            end
            move_valid = 1'b0;
            move_last = 1'b0;
            chk("run_fall", int'(run_a), 0);
            chk("busy_drain", int'(busy_a), 1);
            wait_complete_a(100);
            chk("fin_busy", int'(busy_a), 0);
            chk("fin_x", int'(x_a), tbl[i].ex);
            chk("fin_y", int'(y_a), tbl[i].ey);
            chk("fin_steps", int'(steps_a), tbl[i].esteps);
            chk("fin_oob", int'(oob_a), tbl[i].eoob);
            chk("fin_overflow", int'(overflow_a), 0);
            chk("fin_queue", q_a.size(), 0);
            chk("fin_nsteps", st_a.size(), tbl[i].n);
            for (int k = 1; k < st_a.size(); k++)
                chk("pace_a", st_a[k] - st_a[k-1], 4);
            tick();
            tick();
            chk("no_rearm_complete", int'(complete_a), 1);
            chk("no_rearm_run", int'(run_a), 0);
            done = 1'b0;
        end

        // clear while three entries are still buffered in DRAIN
        do_clear();
        q_a.delete();
        st_a.delete();
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            move_valid = 1'b1;
            move = 2'b01;
            move_last = (k == 3);
            if (k == 0) q_a.push_back(8'h10);
            tick();
        end
        move_valid = 1'b0;
        move_last = 1'b0;
        chk("clr_pre_busy", int'(busy_a), 1);
        do_clear();
        chk("clr_x", int'(x_a), 0);
        chk("clr_y", int'(y_a), 0);
        chk("clr_run", int'(run_a), 0);
        chk("clr_busy", int'(busy_a), 0);
        chk("clr_steps_held", int'(steps_a), 1);
        chk("clr_queue", q_a.size(), 0);
        nsteps = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (step_a) nsteps++;
        end
        chk("clr_no_steps", nsteps, 0);
        chk("clr_idle_complete", int'(complete_a), 0);
        mon_a = 1'b0;

        // Overflow on the STEP_DIV=16 instance: 10 back-to-back strobes
        do_clear();
        mon_b = 1'b1;
        q_b.delete();
        st_b.delete();
        done = 1'b1;
        tick();
        done = 1'b0;
        pos = 8'h00;
        for (int k = 0; k < 10; k++) begin
            move_valid = 1'b1;
            move = 2'b01;
            move_last = (k == 9);
            if (k < 9) begin
                pos = model_step(pos, 2'b01);
                q_b.push_back(pos);
            end
            tick();
        end
        move_valid = 1'b0;
        move_last = 1'b0;
        chk("ovf_flag", int'(overflow_b), 1);
        chk("ovf_run", int'(run_b), 0);
        wait_complete_b(400);
        chk("ovf_steps", int'(steps_b), 9);
        chk("ovf_x", int'(x_b), 9);
        chk("ovf_y", int'(y_b), 0);
        chk("ovf_oob", int'(oob_b), 0);
        chk("ovf_busy", int'(busy_b), 0);
        chk("ovf_queue", q_b.size(), 0);
        for (int k = 1; k < st_b.size(); k++)
            chk("pace_b", st_b[k] - st_b[k-1], 16);

        // Strobe lands on the pop edge while the FIFO is full
        do_clear();
        q_b.delete();
        st_b.delete();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("full_arm_ovf", int'(overflow_b), 0);
        pos = 8'h00;
        for (int k = 0; k < 18; k++) begin
            move_valid = (k <= 8) || (k == 17);
            move = 2'b01;
            move_last = (k == 17);
            if (move_valid) begin
                pos = model_step(pos, 2'b01);
                q_b.push_back(pos);
            end
            tick();
        end
        move_valid = 1'b0;
        move_last = 1'b0;
        chk("full_pop_ovf", int'(overflow_b), 0);
        chk("full_pop_step", int'(step_b), 1);
        wait_complete_b(400);
        chk("full_steps", int'(steps_b), 10);
        chk("full_x", int'(x_b), 10);
        chk("full_ovf_end", int'(overflow_b), 0);
        chk("full_queue", q_b.size(), 0);
        mon_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maze_path_player.md
# maze_path_player

Downstream stage of the maze solver controller. Once the solver reports a solved path, this block requests the move stream, buffers the 2-bit moves in a small FIFO, and replays them at a programmable pace. It walks an (x, y) cursor over the 16x16 grid, so a display or robot stage sees one grid step per STEP_DIV clocks. It reports completion, step count, and error flags.

## Interface
- START_X, 0: cursor column after reset/clear (0..15)
- START_Y, 0: cursor row after reset/clear (0..15)
- STEP_DIV, 4: clocks between successive steps (>=1)
- FIFO_DEPTH, 8: move buffer entries (power of 2, >=2)

- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous, active-low (rst=0 resets on the clk edge)
- done  in  1  solver has a solved path (level)
- move_valid  in  1  one-cycle strobe: move/move_last valid; no backpressure
- move  in  2  direction: 00 up (y-1), 01 right (x+1), 10 left (x-1), 11 down (y+1)
- move_last  in  1  qualified by move_valid; marks final move of the path
- clear  in  1  return to IDLE from any state
- run  out  1  request move stream from solver
- x  out  4  cursor column
- y  out  4  cursor row
- step  out  1  one-cycle pulse, cursor just updated
- steps  out  8  moves applied since arm, saturates at 255
- busy  out  1  state is RUN or DRAIN
- complete  out  1  path replay finished (level)
- oob  out  1  sticky: a move would have left the grid
- overflow  out  1  sticky: move arrived with FIFO full and no pop

## Operation
- States: IDLE, RUN, DRAIN, FINISH.
- Reset (rst=0): state IDLE, x=START_X, y=START_Y, steps=0, FIFO empty, timer=0, last_seen=0. All outputs 0 except x, y.
- IDLE: if done=1, go to RUN on the next edge. Entering RUN clears steps, oob, overflow and last_seen. It reloads x/y to START_X/START_Y.
- RUN: run=1.
  - Each move_valid writes move into the FIFO.
  - move_valid with move_last=1 sets last_seen and moves to DRAIN on the same edge. That move is still written.
- DRAIN: run=0. No writes expected; any move_valid in DRAIN is ignored.
- Pacing, active in RUN and DRAIN:
  - timer counts down to 0.
  - When timer==0 and the FIFO is non-empty: pop, apply the move to x/y, steps+1 (saturating), reload timer to STEP_DIV-1, and pulse step next cycle.
  - If timer==0 and the FIFO is empty, timer holds at 0.
- Move application:
  - If the target is outside 0..15, x/y are unchanged, oob is set, and steps still increments.
  - No wrap-around.
- DRAIN to FINISH: when the FIFO is empty, no pop is pending, and last_seen=1.
- FINISH: complete=1; x/y/steps held. clear returns to IDLE. done alone does not re-arm.
- clear (any state): go to IDLE next edge. FIFO flushed, x/y reload START values. Sticky flags and steps are held until the next arm.
- FIFO boundaries:
  - Simultaneous push and pop while full: legal, count unchanged, no overflow.
  - Push while full without pop: move dropped, overflow=1.
  - Push into empty FIFO: no bypass; earliest pop is the following cycle.

## Timing
- run rises 1 cycle after done is sampled high in IDLE.
- run falls on the edge that accepts move_last.
- Write at edge N: the entry is visible at N+1. With timer==0, the pop and x/y update occur at edge N+1.
- step is high for exactly one cycle, the cycle after the x/y update edge, while the new x/y are already visible.
- Consecutive pops are exactly STEP_DIV cycles apart while the FIFO is non-empty. STEP_DIV=1 gives one step per clock.
- complete rises 1 cycle after the edge that pops the final entry.
- busy drops in the same cycle that complete rises.

## Test plan
- Reset: hold rst=0 for 2 clocks with START=(0,0) -> x=0, y=0, all flags 0, run=0; state IDLE.
- Basic path, STEP_DIV=4:
  - Stimulus: done=1; moves 01, 01, 11 (last) on 3 consecutive strobes.
  - Expect: run high until the 3rd strobe; step pulses 4 cycles apart; x/y go (1,0), (2,0), (2,1); steps=3; complete=1.
- Out of bounds: START=(0,0), move 00 (last) -> x/y stay (0,0), oob=1, steps=1, complete=1.
- Overflow:
  - Stimulus: FIFO_DEPTH=8, STEP_DIV=16; 10 consecutive strobes.
  - Expect: 1 entry popped, 8 buffered, 1 dropped; overflow=1. Replay applies 9 moves, steps=9.
- Full with simultaneous pop: strobe arrives while full in the cycle a pop occurs -> overflow stays 0; count stays 8.
- clear mid-DRAIN: assert clear with 3 entries buffered -> IDLE next cycle; x/y=START; run=0; busy=0. No further step pulses occur.
